// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution / pooling pipeline stages.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    CMP   = 2'd2,
    WRITE = 2'd3
  } pool_state_t;

  // Output map edge length for a square input map.
  function automatic int pool_out_size(input int size, input int pool, input int stride);
    return (size - pool) / stride + 1;
  endfunction

  // Signed maximum; a tie keeps the first argument.
  function automatic logic signed [31:0] signed_max(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_index_counter.sv
// Row-major 2-D window index counter for the pooling scan.
module pool_index_counter #(
  parameter int OUT = 2,
  localparam int IW = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          ena,
  output logic [IW-1:0] orow,
  output logic [IW-1:0] ocol,
  output logic          last
);

  localparam logic [IW-1:0] IDX_MAX = IW'(OUT - 1);

  assign last = (orow == IDX_MAX) && (ocol == IDX_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      orow <= '0;
      ocol <= '0;
    end else if (ena) begin
      if (ocol == IDX_MAX) begin
        ocol <= '0;
        orow <= (orow == IDX_MAX) ? '0 : orow + 1'b1;
      end else begin
        ocol <= ocol + 1'b1;
      end
    end
  end

endmodule

// File: rtl/max_pool2.sv
// Sequential 2-D max-pooling stage: snapshots the feature map on start and
// scans windows one comparison per cycle into a registered output map.
module max_pool2
  import conv_pkg::*;
#(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int STRIDE    = 2,
  parameter int WIDTH_BIT = 8,
  localparam int OUT      = pool_out_size(SIZE, POOL, STRIDE)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] inpMatrixI,
  output logic                                          busy,
  output logic                                          done,
  output logic signed [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]   poolOut
);

  localparam int IW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int KW = (POOL * POOL > 1) ? $clog2(POOL * POOL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(POOL * POOL - 1);

  pool_state_t                                   state;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]      map_buf;
  logic signed [WIDTH_BIT-1:0]                   acc;
  logic [KW-1:0]                                 k;
  logic [IW-1:0]                                 orow;
  logic [IW-1:0]                                 ocol;
  logic                                          last;
  logic [RW-1:0]                                 row_idx;
  logic [RW-1:0]                                 col_idx;
  logic signed [WIDTH_BIT-1:0]                   elem;

  pool_index_counter #(.OUT(OUT)) u_index (
    .clock (clock),
    .reset (reset),
    .clear ((state == IDLE) && start),
    .ena   (state == WRITE),
    .orow  (orow),
    .ocol  (ocol),
    .last  (last)
  );

  // Element k of the current window, row-major inside the window.
  always_comb begin
    row_idx = RW'(int'(orow) * STRIDE + int'(k) / POOL);
    col_idx = RW'(int'(ocol) * STRIDE + int'(k) % POOL);
    elem    = map_buf[row_idx][col_idx];
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; map_buf is cleared on reset because it is observable
  // state that must not leak a previous job after an abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      poolOut <= '0;
      map_buf <= '0;
      acc     <= '0;
      k       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            map_buf <= inpMatrixI;
            k       <= '0;
            busy    <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          acc <= elem;
          if (POOL == 1) begin
            state <= WRITE;
          end else begin
            k     <= KW'(1);
            state <= CMP;
          end
        end
        CMP: begin
          acc <= WIDTH_BIT'(signed_max(32'(acc), 32'(elem)));
          if (k == K_LAST) state <= WRITE;
          else             k     <= k + 1'b1;
        end
        WRITE: begin
          poolOut[orow][ocol] <= acc;
          k <= '0;
          if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool2.sv
// Directed bench for max_pool2: table-driven jobs plus multi-cycle corner cases.
module tb_max_pool2;

  typedef logic signed [4:0][4:0][7:0] map_t;
  typedef logic signed [1:0][1:0][7:0] pmap_t;

  typedef struct {
    string name;
    map_t  m;
    pmap_t exp;
  } vec_t;

  logic  clock = 1'b0;
  logic  reset;
  logic  start;
  map_t  inpMatrixI;
  logic  busy;
  logic  done;
  pmap_t poolOut;

  int n_cmp  = 0;
  int n_fail = 0;

  max_pool2 dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .inpMatrixI (inpMatrixI),
    .busy       (busy),
    .done       (done),
    .poolOut    (poolOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic pmap_t mk_exp(input int a, input int b, input int c, input int d);
    pmap_t p;
    p[0][0] = 8'(a);
    p[0][1] = 8'(b);
    p[1][0] = 8'(c);
    p[1][1] = 8'(d);
    return p;
  endfunction

  function automatic map_t ramp_map();
    map_t m;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[r][c] = 8'(r * 5 + c);
    return m;
  endfunction

  function automatic map_t fill_map(input int v);
    map_t m;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[r][c] = 8'(v);
    return m;
  endfunction

  task automatic check_pool(input string name, input pmap_t exp);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("%s_pool[%0d][%0d]", name, r, c),
              int'($signed(poolOut[r][c])), int'($signed(exp[r][c])));
  endtask

  // Starts a job at edge 0, waits (bounded) for done, checks latency,
  // busy duration, one-cycle done and the resulting map.
  task automatic run_job(input string name, input map_t m, input pmap_t exp);
    int edges;
    int busy_cnt;
    @(negedge clock);
    inpMatrixI = m;
    start      = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    check({name, "_done_edge"}, edges, 20);
    check({name, "_busy_cycles"}, busy_cnt, 20);
    check_pool(name, exp);
    @(posedge clock); #1;
    check({name, "_done_one_cycle"}, int'(done), 0);
  endtask

  vec_t vecs[4];

  initial begin
    int edges;
    int done_cnt;
    int done_edges[$];
    map_t m;

    // Table of whole jobs with hand-computed pooled maps.
    vecs[0].name = "ramp";
    vecs[0].m    = ramp_map();
    vecs[0].exp  = mk_exp(6, 8, 16, 18);

    vecs[1].name = "signed";
    vecs[1].m    = fill_map(-5);
    vecs[1].m[1][1] = -8'sd3;
    vecs[1].exp  = mk_exp(-3, -5, -5, -5);

    vecs[2].name = "edge_drop";
    vecs[2].m    = fill_map(0);
    vecs[2].m[4][4] = 8'sd127;
    vecs[2].exp  = mk_exp(0, 0, 0, 0);

    vecs[3].name = "mixed";
    vecs[3].m    = fill_map(-128);
    vecs[3].m[0][1] = -8'sd1;
    vecs[3].m[2][0] = 8'sd0;
    vecs[3].m[3][1] = 8'sd0;
    vecs[3].m[2][3] = 8'sd127;
    vecs[3].m[2][4] = 8'sd100;
    vecs[3].exp  = mk_exp(-1, -128, 0, 127);

    reset      = 1'b1;
    start      = 1'b0;
    inpMatrixI = ramp_map();
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check_pool("reset", mk_exp(0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) run_job(vecs[i].name, vecs[i].m, vecs[i].exp);

    // Input isolation and start ignored while busy.
    @(negedge clock);
    inpMatrixI = ramp_map();
    start      = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    edges    = 0;
    done_cnt = 0;
    while (edges < 30) begin
      @(posedge clock); #1;
      edges++;
      if (edges == 3) inpMatrixI = fill_map(100);
      if (edges == 4) start = 1'b1;
      if (edges == 5) start = 1'b0;
      if (done) begin
        done_cnt++;
        check("iso_done_edge", edges, 20);
        check_pool("iso", mk_exp(6, 8, 16, 18));
      end
    end
    check("iso_done_count", done_cnt, 1);
    check("iso_busy_after", int'(busy), 0);

    // Reset mid-job aborts without done and clears outputs.
    @(negedge clock);
    inpMatrixI = ramp_map();
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check_pool("rst_mid", mk_exp(0, 0, 0, 0));
    done_cnt = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    check("rst_mid_no_done", done_cnt, 0);
    run_job("after_rst", ramp_map(), mk_exp(6, 8, 16, 18));

    // Continuous start: jobs back to back every 21 edges.
    @(negedge clock);
    inpMatrixI = ramp_map();
    start      = 1'b1;
    @(posedge clock); #1;
    edges = 0;
    while (edges < 62) begin
      @(posedge clock); #1;
      edges++;
      if (done) done_edges.push_back(edges);
    end
    start = 1'b0;
    check("cont_done_count", done_edges.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("cont_done_edge%0d", i),
            (i < done_edges.size()) ? done_edges[i] : -1, 20 + 21 * i);
    check_pool("cont", mk_exp(6, 8, 16, 18));
    @(posedge clock); #1;
    check("cont_idle_busy", int'(busy), 0);
    check("cont_idle_done", int'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
